shift_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the N-bit normalising shift register and drives its `pin1`, `ld` and `shr` inputs. On a `start` request it captures an operand, loads it into the register, then issues right-shift pulses until the register reports its `half` condition or a shift cap is reached. It returns the shift count, a cap-hit flag and the register's `mid` bit sampled at the stop point. It is the only source of `ld`/`shr` for that register.

---
 rtl/shift_ctrl_pkg.sv | 25 ++
 rtl/shift_ctrl_counter.sv | 27 ++
 rtl/shift_ctrl.sv | 105 ++++++++++
 tb/tb_shift_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift register sequencing controller.
//   state_t      : FSM state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//   maxs_of(n)   : shift cap for an n-bit register (n/2)
//   cw_of(n)     : width of a counter holding 0..maxs_of(n)
// The register's own bench imports maxs_of/cw_of so both sides agree on the cap.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEF = 16;

  function automatic int maxs_of(input int n);
    return n / 2;
  endfunction

  function automatic int cw_of(input int n);
    return $clog2(n / 2 + 1);
  endfunction

endpackage

// File: rtl/shift_ctrl_counter.sv
// Saturating shift counter.
//   clk, rst : clock, synchronous active-low reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment enable, ignored once saturated
//   cnt      : current count, 0..MAXS
//   sat      : cnt == MAXS
module shift_counter #(
  parameter int MAXS = 8,
  parameter int CW   = $clog2(MAXS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  assign sat = (cnt == CW'(MAXS));

  always_ff @(posedge clk) begin
    if (!rst)             cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/shift_ctrl.sv
// Sequencing controller for the N-bit normalising shift register.
// On start: capture din, pulse ld once, then pulse shr until the register
// reports half or MAXS shifts have been issued.
//   clk, rst : clock, synchronous active-low reset
//   start    : request, honoured only in IDLE
//   din      : operand, sampled with start
//   half     : stop condition from the register (combinational from pout)
//   mid      : register mid tap
//   pin1     : captured operand to register parallel input
//   ld, shr  : register load / shift-right enables
//   busy     : state != IDLE
//   done     : one-cycle completion pulse
//   shcnt    : shr pulses issued by the last operation
//   zero     : last operation stopped on the cap
//   mid_q    : mid sampled at the stop cycle
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int MAXS = maxs_of(N),
  parameter int CW   = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  din,
  input  logic          half,
  input  logic          mid,
  output logic [N-1:0]  pin1,
  output logic          ld,
  output logic          shr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] shcnt,
  output logic          zero,
  output logic          mid_q
);

  state_t state, state_nxt;
  logic   accept;   // start taken in IDLE
  logic   stop;     // SHIFT terminates this cycle
  logic   sat;

  shift_counter #(.MAXS(MAXS), .CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (shr),
    .cnt (shcnt),
    .sat (sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // half has priority over the cap so a stop exactly at MAXS reports zero=0.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    shr       = 1'b0;
    accept    = 1'b0;
    stop      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        ld        = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (half || sat) begin
          stop      = 1'b1;
          state_nxt = DONE;
        end else begin
          shr = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pin1  <= '0;
      zero  <= 1'b0;
      mid_q <= 1'b0;
    end else if (accept) begin
      pin1  <= din;
      zero  <= 1'b0;
      mid_q <= 1'b0;
    end else if (stop) begin
      zero  <= !half;
      mid_q <= mid;
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;
  import shift_ctrl_pkg::*;

  localparam int N    = 16;
  localparam int MAXS = maxs_of(N);
  localparam int CW   = cw_of(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  din;
  logic          half, mid;
  logic [N-1:0]  pin1;
  logic          ld, shr, busy, done, zero, mid_q;
  logic [CW-1:0] shcnt;

  int n_run = 0;
  int n_fail = 0;

  shift_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .half(half), .mid(mid),
    .pin1(pin1), .ld(ld), .shr(shr), .busy(busy), .done(done),
    .shcnt(shcnt), .zero(zero), .mid_q(mid_q)
  );

  always #5 clk = ~clk;

  // Behavioural shift register; half is abstracted as "stop_k shifts seen".
  logic [N-1:0] pout = '0;
  int nshift = 0;
  int stop_k = 1000;
  always @(posedge clk) begin
    if (ld) begin
      pout   <= pin1;
      nshift <= 0;
    end else if (shr) begin
      pout   <= pout >> 1;
      nshift <= nshift + 1;
    end
  end
  assign half = (nshift >= stop_k);
  assign mid  = pout[N/2-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation starting in an IDLE cycle; returns in the IDLE cycle after done.
  task automatic run_op(input string nm, input logic [N-1:0] d, input int k, input int busy_c,
                        input int exp_n, input int exp_done, input int exp_zero, input int exp_mid);
    int ld_c, nld, nshr, first_s, last_s, done_c, both;
    ld_c = -1; nld = 0; nshr = 0; first_s = -1; last_s = -1; done_c = -1; both = 0;
    chk({nm, "_idle"}, 32'(busy), 32'(0));
    din = d; start = 1'b1; stop_k = k;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      tick();
      start = 1'b0;
      din   = 16'h5A5A ^ 16'(c);   // junk outside the start cycle
      if (c == busy_c) begin
        start = 1'b1;
        din   = 16'hFFFF;
      end
      if (ld) begin nld++; if (ld_c < 0) ld_c = c; end
      if (shr) begin nshr++; if (first_s < 0) first_s = c; last_s = c; end
      if (ld && shr) both++;
      if (done) done_c = c;
    end
    start = 1'b0;
    chk({nm, "_ld_cyc"}, 32'(ld_c), 32'(1));
    chk({nm, "_ld_cnt"}, 32'(nld), 32'(1));
    chk({nm, "_shr_cnt"}, 32'(nshr), 32'(exp_n));
    chk({nm, "_shr_first"}, 32'(first_s), (exp_n > 0) ? 32'(2) : 32'hFFFF_FFFF);
    chk({nm, "_shr_last"}, 32'(last_s), (exp_n > 0) ? 32'(exp_n + 1) : 32'hFFFF_FFFF);
    chk({nm, "_ld_shr_both"}, 32'(both), 32'(0));
    chk({nm, "_done_cyc"}, 32'(done_c), 32'(exp_done));
    chk({nm, "_shcnt"}, 32'(shcnt), 32'(exp_n));
    chk({nm, "_zero"}, 32'(zero), 32'(exp_zero));
    chk({nm, "_mid_q"}, 32'(mid_q), 32'(exp_mid));
    chk({nm, "_pin1"}, 32'(pin1), 32'(d));
    tick();
    chk({nm, "_post_done"}, 32'(done), 32'(0));
    chk({nm, "_post_busy"}, 32'(busy), 32'(0));
    chk({nm, "_hold_shcnt"}, 32'(shcnt), 32'(exp_n));
    chk({nm, "_hold_pin1"}, 32'(pin1), 32'(d));
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; din = '0;
    tick(); tick();
    chk("rst_pin1", 32'(pin1), 32'(0));
    chk("rst_ld", 32'(ld), 32'(0));
    chk("rst_shr", 32'(shr), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_shcnt", 32'(shcnt), 32'(0));
    chk("rst_zero", 32'(zero), 32'(0));
    chk("rst_mid_q", 32'(mid_q), 32'(0));
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      din = 16'h1111 * 16'(i);
      tick();
      if (busy || ld || shr) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'(0));
    chk("idle_pin1", 32'(pin1), 32'(0));

    //     name    din      k    busy_c shifts done zero mid
    run_op("imm",  16'hF0F0, 0,    0,   0,    3,   0,   1);
    run_op("norm", 16'h0A3C, 3,    3,   3,    6,   0,   0);
    run_op("cap",  16'h0000, 1000, 0,   MAXS, 11,  1,   0);
    // started in the cycle right after the previous done's IDLE return
    run_op("b2b",  16'h0100, 1,    0,   1,    4,   0,   1);

    // Reset in the second SHIFT cycle
    din = 16'h1234; start = 1'b1; stop_k = 1000;
    tick(); start = 1'b0;   // LOAD
    tick();                 // SHIFT 1
    tick();                 // SHIFT 2
    chk("mrst_shifting", 32'(shr), 32'(1));
    rst = 1'b0;
    tick();
    chk("mrst_pin1", 32'(pin1), 32'(0));
    chk("mrst_ld", 32'(ld), 32'(0));
    chk("mrst_shr", 32'(shr), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_done", 32'(done), 32'(0));
    chk("mrst_shcnt", 32'(shcnt), 32'(0));
    chk("mrst_zero", 32'(zero), 32'(0));
    chk("mrst_mid_q", 32'(mid_q), 32'(0));
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || ld || shr || busy) bad++;
    end
    chk("mrst_quiet", 32'(bad), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
